// File: rtl/irrigation_timer.sv
// Loadable down-counting irrigation timer: holds the valve open for DURATION ticks
// of PRESCALE clocks each, with pause/resume, abort and a one-cycle DONE pulse.
module irrigation_timer #(
    parameter int CNT_WIDTH = 6,
    parameter int PRESCALE  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LOAD,
    input  logic [CNT_WIDTH-1:0] DURATION,
    input  logic                 START,
    input  logic                 PAUSE,
    input  logic                 ABORT,
    output logic [CNT_WIDTH-1:0] COUNT,
    output logic                 VALVE,
    output logic                 DONE,
    output logic                 BUSY,
    output logic [1:0]           STATE
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10,
        S_DONE   = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic                 valve_q, valve_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 tick_due;
    logic                 finish;
    logic [PW-1:0]        pre_adv;
    logic [CNT_WIDTH-1:0] cnt_adv;

    // One run-cycle step of the prescaler/counter, shared by RUN and by the resume edge.
    assign tick_due = (pre_q == PRE_LAST);
    assign finish   = tick_due && (count_q == CNT_WIDTH'(1));
    assign pre_adv  = tick_due ? '0 : pre_q + PW'(1);
    assign cnt_adv  = (tick_due && (count_q != '0)) ? count_q - CNT_WIDTH'(1) : count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        valve_d = valve_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (LOAD) begin
                    count_d = DURATION;
                end else if (START && (count_q != '0)) begin
                    state_d = S_RUN;
                    valve_d = 1'b1;
                    pre_d   = '0;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                    valve_d = 1'b0;
                end else if (PAUSE) begin
                    state_d = S_PAUSED;
                    valve_d = 1'b0;
                end else begin
                    pre_d   = pre_adv;
                    count_d = cnt_adv;
                    if (finish) begin
                        state_d = S_DONE;
                        valve_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end else if (START) begin
                    // The pause edge consumed a valve-high cycle without advancing,
                    // so the resume edge takes that step to keep on-time exact.
                    pre_d   = pre_adv;
                    count_d = cnt_adv;
                    if (finish) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        valve_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            count_q <= '0;
            pre_q   <= '0;
            valve_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            valve_q <= valve_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign COUNT = count_q;
    assign VALVE = valve_q;
    assign DONE  = done_q;
    assign BUSY  = busy_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_irrigation_timer.sv
// Self-checking bench for irrigation_timer: table-driven vectors plus scripted
// multi-cycle sequences, expected results queued at drive time and popped after the edge.
module tb_irrigation_timer;

    typedef struct packed {
        logic [5:0] cnt;
        logic       vlv;
        logic       dn;
        logic       bsy;
        logic [1:0] stt;
    } exp_t;

    typedef struct packed {
        logic       ld;
        logic       st;
        logic       pa;
        logic       ab;
        logic [5:0] dur;
        exp_t       e;
    } vec_t;

    logic       CLK;
    logic       RESET;
    logic       ld4, st4, pa4, ab4, ld1, st1, pa1, ab1;
    logic [5:0] dur4, dur1, cnt4, cnt1;
    logic       vlv4, dn4, bsy4, vlv1, dn1, bsy1;
    logic [1:0] stt4, stt1;

    int   errors = 0;
    int   checks = 0;
    int   vhigh  = 0;
    int   ndone  = 0;
    exp_t sbq[$];
    vec_t vt[10];

    irrigation_timer #(.CNT_WIDTH(6), .PRESCALE(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .LOAD(ld4), .DURATION(dur4), .START(st4),
        .PAUSE(pa4), .ABORT(ab4), .COUNT(cnt4), .VALVE(vlv4), .DONE(dn4),
        .BUSY(bsy4), .STATE(stt4)
    );

    irrigation_timer #(.CNT_WIDTH(6), .PRESCALE(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .LOAD(ld1), .DURATION(dur1), .START(st1),
        .PAUSE(pa1), .ABORT(ab1), .COUNT(cnt1), .VALVE(vlv1), .DONE(dn1),
        .BUSY(bsy1), .STATE(stt1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic exp_t mk(input logic [5:0] c, input logic v, input logic d,
                                input logic b, input logic [1:0] s);
        exp_t r;
        r.cnt = c; r.vlv = v; r.dn = d; r.bsy = b; r.stt = s;
        return r;
    endfunction

    function automatic exp_t f_idle(input logic [5:0] c);
        return mk(c, 1'b0, 1'b0, 1'b0, 2'b00);
    endfunction
    function automatic exp_t f_run(input logic [5:0] c);
        return mk(c, 1'b1, 1'b0, 1'b1, 2'b01);
    endfunction
    function automatic exp_t f_pause(input logic [5:0] c);
        return mk(c, 1'b0, 1'b0, 1'b1, 2'b10);
    endfunction
    function automatic exp_t f_done();
        return mk(6'd0, 1'b0, 1'b1, 1'b0, 2'b11);
    endfunction

    function automatic vec_t mkv(input logic ld, input logic st, input logic pa,
                                 input logic ab, input logic [5:0] dur, input exp_t e);
        vec_t v;
        v.ld = ld; v.st = st; v.pa = pa; v.ab = ab; v.dur = dur; v.e = e;
        return v;
    endfunction

    function automatic void chk(input string nm, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got cnt=%0d valve=%b done=%b busy=%b state=%b, want cnt=%0d valve=%b done=%b busy=%b state=%b",
                     nm, act.cnt, act.vlv, act.dn, act.bsy, act.stt,
                     exp.cnt, exp.vlv, exp.dn, exp.bsy, exp.stt);
        end
    endfunction

    function automatic void chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endfunction

    function automatic exp_t act4();
        exp_t a;
        a = {cnt4, vlv4, dn4, bsy4, stt4};
        return a;
    endfunction
    function automatic exp_t act1();
        exp_t a;
        a = {cnt1, vlv1, dn1, bsy1, stt1};
        return a;
    endfunction

    task automatic step(input bit p1, input logic ld, input logic st, input logic pa,
                        input logic ab, input logic [5:0] dur, input exp_t e, input string nm);
        exp_t a;
        @(negedge CLK);
        if (p1) begin
            ld1 = ld; st1 = st; pa1 = pa; ab1 = ab; dur1 = dur;
        end else begin
            ld4 = ld; st4 = st; pa4 = pa; ab4 = ab; dur4 = dur;
        end
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        a = p1 ? act1() : act4();
        if (a.vlv) vhigh++;
        if (a.dn) ndone++;
        chk(nm, a, sbq.pop_front());
    endtask

    task automatic idle4(input exp_t e, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, e, nm);
    endtask

    initial begin
        RESET = 1'b0;
        {ld4, st4, pa4, ab4, ld1, st1, pa1, ab1} = '0;
        dur4 = '0;
        dur1 = '0;

        vt[0] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_idle(6'd0));
        vt[1] = mkv(1'b0, 1'b0, 1'b1, 1'b1, 6'd0, f_idle(6'd0));
        vt[2] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 6'd7, f_idle(6'd7));
        vt[3] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, f_idle(6'd7));
        vt[4] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd7));
        vt[5] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 6'd9, f_run(6'd7));
        vt[6] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, f_idle(6'd0));
        vt[7] = mkv(1'b1, 1'b0, 1'b1, 1'b0, 6'd5, f_idle(6'd5));
        vt[8] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, f_idle(6'd0));
        vt[9] = mkv(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_idle(6'd0));

        repeat (2) @(posedge CLK);
        #2;
        chk("reset_p4", act4(), f_idle(6'd0));
        chk("reset_p1", act1(), f_idle(6'd0));
        @(negedge CLK);
        RESET = 1'b1;
        idle4(f_idle(6'd0), "post_reset");

        for (int i = 0; i < 10; i++)
            step(1'b0, vt[i].ld, vt[i].st, vt[i].pa, vt[i].ab, vt[i].dur, vt[i].e,
                 $sformatf("vec%0d", i));

        // Full uninterrupted run, DURATION=3, with LOAD/START noise during RUN
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, f_idle(6'd3), "run_load");
        vhigh = 0; ndone = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd3), "run_start");
        for (int k = 1; k <= 12; k++) begin
            exp_t e;
            e = (k == 12) ? f_done() : f_run(6'(3 - k / 4));
            step(1'b0, (k == 2), (k == 3), 1'b0, 1'b0, 6'd9, e, $sformatf("run_k%0d", k));
        end
        idle4(f_idle(6'd0), "run_after_done");
        chk_int("run_valve_cycles", vhigh, 12);
        chk_int("run_done_pulses", ndone, 1);

        // Pause after 6 cycles, hold paused, resume
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2, f_idle(6'd2), "pz_load");
        vhigh = 0; ndone = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd2), "pz_start");
        for (int k = 1; k <= 5; k++)
            idle4(f_run(6'(2 - k / 4)), $sformatf("pz_k%0d", k));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, f_pause(6'd1), "pz_pause");
        for (int j = 0; j < 10; j++)
            step(1'b0, (j == 4), 1'b0, 1'b1, 1'b0, 6'd9, f_pause(6'd1), $sformatf("pz_hold%0d", j));
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd1), "pz_resume");
        idle4(f_run(6'd1), "pz_r1");
        idle4(f_done(), "pz_done");
        idle4(f_idle(6'd0), "pz_idle");
        chk_int("pz_valve_cycles", vhigh, 8);
        chk_int("pz_done_pulses", ndone, 1);

        // Abort from RUN five cycles after START
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd4, f_idle(6'd4), "ab_load");
        ndone = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd4), "ab_start");
        for (int k = 1; k <= 4; k++)
            idle4(f_run(6'(4 - k / 4)), $sformatf("ab_k%0d", k));
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, f_idle(6'd0), "ab_abort");
        for (int k = 0; k < 3; k++)
            idle4(f_idle(6'd0), $sformatf("ab_idle%0d", k));
        chk_int("ab_done_pulses", ndone, 0);

        // Abort from PAUSED beats a simultaneous START
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, f_idle(6'd3), "pa_load");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd3), "pa_start");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, f_pause(6'd3), "pa_pause");
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, f_idle(6'd0), "pa_abort");

        // Asynchronous reset in the middle of a run
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5, f_idle(6'd5), "rs_load");
        ndone = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd5), "rs_start");
        for (int k = 1; k <= 3; k++)
            idle4(f_run(6'd5), $sformatf("rs_k%0d", k));
        #2;
        RESET = 1'b0;
        #1;
        chk("rs_async", act4(), f_idle(6'd0));
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK);
            #1;
            if (dn4) ndone++;
            chk($sformatf("rs_hold%0d", k), act4(), f_idle(6'd0));
        end
        @(negedge CLK);
        RESET = 1'b1;
        idle4(f_idle(6'd0), "rs_release");
        chk_int("rs_done_pulses", ndone, 0);

        // PRESCALE=1 instance
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, f_idle(6'd1), "p1_load1");
        vhigh = 0; ndone = 0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd1), "p1_start1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, f_done(), "p1_done1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, f_idle(6'd0), "p1_idle1");
        chk_int("p1_valve_cycles", vhigh, 1);
        chk_int("p1_done_pulses", ndone, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, f_idle(6'd3), "p1_load3");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, f_run(6'd3), "p1_start3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, f_run(6'd2), "p1_c2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, f_run(6'd1), "p1_c1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, f_done(), "p1_done3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, f_idle(6'd0), "p1_idle3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
